// File: rtl/pipe_stage_register_pkg.sv
// pipe_stage_register_pkg: shared widths and state encoding for the elastic pipeline register.
package pipe_stage_register_pkg;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 101;
    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_FULL  = 2'd1,
        PSR_SKID  = 2'd2
    } psr_state_t;
endpackage

// File: rtl/pipe_stage_register_skid_slot.sv
// pipe_stage_register_skid_slot: one ctrl+data storage slot with load enable and sync active-low clear.
module pipe_stage_register_skid_slot #(
    parameter int W = 109
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_ld,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (!reset_n) r_q <= '0;
        else if (i_ld) r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_register.sv
// pipe_stage_register: valid/ready pipeline register with 2-entry skid storage and sync flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble cycle counters.
module pipe_stage_register
    import pipe_stage_register_pkg::*;
#(
    parameter int                CTRL_W   = MEM_WB_CTRL_W,
    parameter int                DATA_W   = MEM_WB_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);
    localparam int W = CTRL_W + DATA_W;
    psr_state_t r_state, w_next;
    logic w_in_fire, w_out_fire, w_main_ld, w_skid_ld;
    logic [W-1:0] w_main_d, w_main_q, w_skid_q;
    assign in_ready   = (r_state != PSR_SKID);
    assign out_valid  = (r_state != PSR_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    // In SKID the older entry sits in main, so main refills from skid, never from input.
    assign w_main_ld = !flush && ((r_state == PSR_SKID) ? w_out_fire
                                  : w_in_fire && (r_state == PSR_EMPTY || out_ready));
    assign w_skid_ld = !flush && (r_state == PSR_FULL) && w_in_fire && !out_ready;
    assign w_main_d  = (r_state == PSR_SKID) ? w_skid_q : {in_ctrl, in_data};
    always_comb begin
        w_next = r_state;
        if (flush) w_next = PSR_EMPTY;
        else if (r_state == PSR_EMPTY) w_next = w_in_fire ? PSR_FULL : PSR_EMPTY;
        else if (r_state == PSR_FULL)
            w_next = (w_in_fire && !out_ready) ? PSR_SKID
                   : (w_out_fire && !w_in_fire) ? PSR_EMPTY : PSR_FULL;
        else if (r_state == PSR_SKID) w_next = w_out_fire ? PSR_FULL : PSR_SKID;
        else w_next = PSR_EMPTY;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= PSR_EMPTY;
        else r_state <= w_next;
    end
    pipe_stage_register_skid_slot #(.W(W)) u_main (
        .clk(clk), .reset_n(reset_n), .i_ld(w_main_ld), .i_d(w_main_d), .o_q(w_main_q)
    );
    pipe_stage_register_skid_slot #(.W(W)) u_skid (
        .clk(clk), .reset_n(reset_n), .i_ld(w_skid_ld), .i_d({in_ctrl, in_data}), .o_q(w_skid_q)
    );
    assign out_ctrl = out_valid ? w_main_q[W-1:DATA_W] : CTRL_RST;
    assign out_data = w_main_q[DATA_W-1:0];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt, r_bubble_cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (out_ready && !out_valid && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_pipe_stage_register.sv
// tb_pipe_stage_register: directed and random stimulus against a 2-deep FIFO reference model.
module tb_pipe_stage_register;
    localparam int CW = 8;
    localparam int DW = 101;
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    logic          clk = 1'b0;
    logic          reset_n, flush, in_valid, out_ready, in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt, bubble_cnt;
`endif
    ent_t          q[$];
    logic [DW-1:0] m_last;
    logic [31:0]   m_stall, m_bubble;
    int            checks = 0;
    int            failures = 0;
    always #5 clk = ~clk;
    pipe_stage_register dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Model: a FIFO of at most two entries whose head is the output; ready means "not full".
    task automatic tick();
        bit rdy, vld;
        rdy = q.size() < 2;
        vld = q.size() > 0;
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            m_last = '0;
            m_stall = 0;
            m_bubble = 0;
        end else begin
            if (vld && !out_ready && m_stall != '1) m_stall++;
            if (out_ready && !vld && m_bubble != '1) m_bubble++;
            if (flush) q.delete();
            else begin
                if (vld && out_ready) void'(q.pop_front());
                if (in_valid && rdy) q.push_back({in_ctrl, in_data});
            end
        end
        if (q.size() > 0) m_last = q[0].d;
        #1;
        chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
        chk("in_ready", {127'd0, in_ready}, {127'd0, q.size() < 2});
        chk("out_ctrl", {120'd0, out_ctrl}, (q.size() > 0) ? {120'd0, q[0].c} : 128'd0);
        chk("out_data", {27'd0, out_data}, {27'd0, m_last});
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", {96'd0, stall_cnt}, {96'd0, m_stall});
        chk("bubble_cnt", {96'd0, bubble_cnt}, {96'd0, m_bubble});
`endif
    endtask
    task automatic drive(input bit v, input bit r, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        out_ready = r;
        in_ctrl = c;
        in_data = d;
    endtask
    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    initial begin
        m_last = '0;
        m_stall = 0;
        m_bubble = 0;
        reset_n = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 8'h3C, 101'h55);
        tick();
        tick();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_ctrl", {120'd0, out_ctrl}, 128'd0);
        chk("rst_out_data", {27'd0, out_data}, 128'd0);
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 8'hA5, DW'(i));
            tick();
            chk("stream_lag", {27'd0, out_data}, 128'(i));
        end
        drive(1'b0, 1'b1, 8'h00, '0);
        tick();
        begin
            int k;
            k = 1;
            for (int i = 0; i < 4; i++) begin
                drive(k <= 3, 1'b0, 8'h11, DW'(k));
                if (in_ready && k <= 3) k++;
                tick();
            end
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            for (int i = 0; i < 6; i++) begin
                drive(k <= 3, 1'b1, 8'h11, DW'(k));
                if (in_ready && k <= 3) k++;
                tick();
            end
        end
        drive(1'b1, 1'b0, 8'h21, 101'd100);
        tick();
        drive(1'b1, 1'b0, 8'h22, 101'd101);
        tick();
        flush = 1'b1;
        drive(1'b1, 1'b0, 8'h23, 101'd102);
        tick();
        flush = 1'b0;
        chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
        drive(1'b0, 1'b1, 8'h00, '0);
        tick();
        tick();
        drive(1'b1, 1'b0, 8'h31, 101'd200);
        tick();
        drive(1'b1, 1'b0, 8'h32, 101'd201);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_mid_out_data", {27'd0, out_data}, 128'd0);
        chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
`ifdef PIPE_STAGE_PERF_EN
        drive(1'b1, 1'b0, 8'h41, 101'd300);
        tick();
        drive(1'b0, 1'b0, 8'h00, '0);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b1, 8'h00, '0);
        for (int i = 0; i < 4; i++) tick();
        chk("perf_stall5", {96'd0, stall_cnt}, 128'd5);
        chk("perf_bubble3", {96'd0, bubble_cnt}, 128'd3);
        drive(1'b0, 1'b0, 8'h00, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_flush_stall", {96'd0, stall_cnt}, 128'd5);
        chk("perf_flush_bubble", {96'd0, bubble_cnt}, 128'd3);
`endif
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, CW'($urandom), rnd_data());
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
